program_feeder: RTL and testbench
=================================

PROGRAM_FEEDER -- requirements
Module: program_feeder

Interface
REQ-001 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-002 RST  input  1  reset, synchronous, active-high.
REQ-003 SW_DATA  input  10  word to store; sampled on an accepted load.
REQ-004 LOAD_STB  input  1  level input from a debounced key; the block detects its rising edge internally.
REQ-005 RUN_STB  input  1  level input from a debounced key; the block detects its rising edge internally.
REQ-006 EXT  input  1  processor external-input enable; each CLK cycle with EXT=1 consumes the presented word.
REQ-007 DATA_OUT  output  10  word presented to the processor input data bus.
REQ-008 DATA_VALID  output  1  DATA_OUT holds a stored word.
REQ-009 COUNT  output  5  number of stored words, 0..16.
REQ-010 RD_PTR  output  4  index of the next word to be consumed.
REQ-011 STATE  output  2  LOAD=00, RUN=01, HALT=10; 11 is unused.
REQ-012 ERR  output  1  sticky error flag.

Function
REQ-013 Storage SHALL be 16 x 10-bit words with a 4-bit write pointer WR_PTR, a 4-bit read pointer RD_PTR and a 5-bit COUNT.
REQ-014 Edge detection SHALL use registered previous values of LOAD_STB and RUN_STB; an edge is the current value 1 with the previous value 0; holding a key produces exactly one event.
REQ-015 Load event in LOAD state with COUNT<16:
- mem[WR_PTR] <= SW_DATA
- WR_PTR and COUNT increment next cycle.
REQ-016 Load event in LOAD state with COUNT=16:
- storage is unchanged
- ERR <= 1 (overflow).
REQ-017 Run event in LOAD state with COUNT>0: STATE <= RUN and RD_PTR <= 0 next cycle.
REQ-018 Run event in LOAD state with COUNT=0: ignored; STATE stays LOAD and ERR is unchanged.
REQ-019 Load and run events in the same cycle in LOAD state: the load is processed and the run is discarded.
REQ-020 In RUN state, DATA_OUT SHALL equal mem[RD_PTR] combinationally (zero latency) and DATA_VALID SHALL be 1.
REQ-021 In LOAD and HALT states, DATA_OUT SHALL be 0 and DATA_VALID SHALL be 0.
REQ-022 In RUN state, a cycle with EXT=1 consumes mem[RD_PTR]; RD_PTR increments next cycle.
REQ-023 If the consumed index equals COUNT-1, the next cycle SHALL have STATE <= HALT and RD_PTR <= 0.
REQ-024 RD_PTR SHALL wrap from 15 to 0 only through the HALT transition; it never exceeds COUNT-1 in RUN.
REQ-025 EXT=1 in LOAD or HALT state: underrun; ERR <= 1 and no pointer changes.
REQ-026 Load and run events in RUN state SHALL be ignored.
REQ-027 Run event in HALT state: STATE <= RUN, RD_PTR <= 0; the stored program replays unchanged.
REQ-028 Load event in HALT state SHALL be ignored.
REQ-029 ERR SHALL clear only on RST.
REQ-030 COUNT SHALL be unchanged by RUN and HALT activity.

Reset
REQ-031 RST=1 at a rising edge SHALL set:
- STATE=LOAD
- WR_PTR=0, RD_PTR=0, COUNT=0
- ERR=0
- edge-detect registers = 0.
REQ-032 While in reset, DATA_OUT=0 and DATA_VALID=0.
REQ-033 Memory contents are not cleared; they are unreachable until rewritten, because COUNT=0.
REQ-034 RST SHALL take priority over every event in the same cycle, including RST asserted mid-RUN with EXT=1.
REQ-035 A key held high through reset release SHALL NOT generate an edge.

Verification
REQ-036 Load 0x2A5, 0x013, 0x3FF, then a run event -> STATE=01, DATA_OUT=0x2A5; EXT pulses give 0x013, then 0x3FF; the next cycle STATE=10, DATA_VALID=0.
REQ-037 Load 17 words -> COUNT=16, ERR=1, word 0 intact; a run event then replays all 16 words in order.
REQ-038 Run event with COUNT=0 -> STATE stays 00, ERR=0; EXT=1 in LOAD -> ERR=1.
REQ-039 After HALT, a run event -> replay from RD_PTR=0 with identical words; EXT in HALT before the run event -> ERR=1.
REQ-040 Simultaneous load and run edges in LOAD with COUNT=2 -> COUNT=3, STATE=00.
REQ-041 RST asserted mid-RUN with EXT=1 and RD_PTR=2 -> next cycle STATE=00, COUNT=0, RD_PTR=0, DATA_VALID=0, ERR=0.

Source files
------------

// File: rtl/program_feeder.sv
// program_feeder: 16-word program store loaded from switches and replayed
// word by word onto a processor input bus under EXT handshakes.
module program_feeder (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] SW_DATA,
    input  logic       LOAD_STB,
    input  logic       RUN_STB,
    input  logic       EXT,
    output logic [9:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic [4:0] COUNT,
    output logic [3:0] RD_PTR,
    output logic [1:0] STATE,
    output logic       ERR
);
    typedef enum logic [1:0] {S_LOAD = 2'b00, S_RUN = 2'b01, S_HALT = 2'b10} state_t;
    state_t     state_q, state_d;
    logic [3:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0] count_q, count_d;
    logic       err_q, err_d;
    logic       load_prev_q, load_prev_d, run_prev_q, run_prev_d, arm_q, arm_d;
    logic [9:0] mem_q [16];
    logic       load_ev, run_ev, mem_we, last;

    // arm_q masks the first cycle after reset so a key held through reset release is not an edge
    always_comb begin
        load_prev_d = LOAD_STB;
        run_prev_d  = RUN_STB;
        arm_d       = 1'b1;
        load_ev     = arm_q & LOAD_STB & ~load_prev_q;
        run_ev      = arm_q & RUN_STB & ~run_prev_q;
        last        = {1'b0, rd_ptr_q} == count_q - 5'd1;
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (load_ev) begin
                    if (count_q == 5'd16) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 4'd1;
                        count_d  = count_q + 5'd1;
                    end
                end else if (run_ev && count_q != 5'd0) begin
                    state_d  = S_RUN;
                    rd_ptr_d = 4'd0;
                end
                if (EXT) err_d = 1'b1;
            end
            S_RUN: begin
                if (EXT) begin
                    rd_ptr_d = last ? 4'd0 : rd_ptr_q + 4'd1;
                    state_d  = last ? S_HALT : S_RUN;
                end
            end
            S_HALT: begin
                if (run_ev) begin
                    state_d  = S_RUN;
                    rd_ptr_d = 4'd0;
                end
                if (EXT) err_d = 1'b1;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_LOAD;
            wr_ptr_q    <= 4'd0;
            rd_ptr_q    <= 4'd0;
            count_q     <= 5'd0;
            err_q       <= 1'b0;
            load_prev_q <= 1'b0;
            run_prev_q  <= 1'b0;
            arm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            load_prev_q <= load_prev_d;
            run_prev_q  <= run_prev_d;
            arm_q       <= arm_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we && !RST) mem_q[wr_ptr_q] <= SW_DATA;
    end

    assign DATA_VALID = (state_q == S_RUN) && !RST;
    assign DATA_OUT   = DATA_VALID ? mem_q[rd_ptr_q] : 10'd0;
    assign COUNT      = count_q;
    assign RD_PTR     = rd_ptr_q;
    assign STATE      = state_q;
    assign ERR        = err_q;
endmodule

// File: tb/tb_program_feeder.sv
// tb_program_feeder: directed checks of load, replay, halt, error and reset behaviour.
module tb_program_feeder;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [9:0] SW_DATA = 10'd0;
    logic       LOAD_STB = 1'b0;
    logic       RUN_STB = 1'b0;
    logic       EXT = 1'b0;
    logic [9:0] DATA_OUT;
    logic       DATA_VALID;
    logic [4:0] COUNT;
    logic [3:0] RD_PTR;
    logic [1:0] STATE;
    logic       ERR;
    int         total = 0;
    int         bad = 0;

    program_feeder dut (
        .CLK(CLK), .RST(RST), .SW_DATA(SW_DATA), .LOAD_STB(LOAD_STB), .RUN_STB(RUN_STB),
        .EXT(EXT), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .COUNT(COUNT),
        .RD_PTR(RD_PTR), .STATE(STATE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [9:0] d);
        SW_DATA = d;
        LOAD_STB = 1'b1;
        tick();
        LOAD_STB = 1'b0;
        tick();
    endtask

    task automatic run_key();
        RUN_STB = 1'b1;
        tick();
        RUN_STB = 1'b0;
        tick();
    endtask

    task automatic ext_pulse();
        EXT = 1'b1;
        tick();
        EXT = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
    endtask

    function automatic logic [9:0] wv(input int i);
        return 10'(i * 37 + 5);
    endfunction

    initial begin
        LOAD_STB = 1'b1;
        tick();
        tick();
        chk("rst_state", STATE, 2'b00);
        chk("rst_count", COUNT, 5'd0);
        chk("rst_rdptr", RD_PTR, 4'd0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_valid", DATA_VALID, 1'b0);
        chk("rst_data", DATA_OUT, 10'd0);
        RST = 1'b0;
        tick();
        tick();
        chk("held_key_no_edge", COUNT, 5'd0);
        LOAD_STB = 1'b0;
        tick();

        run_key();
        chk("run_empty_state", STATE, 2'b00);
        chk("run_empty_err", ERR, 1'b0);
        ext_pulse();
        chk("ext_load_err", ERR, 1'b1);
        do_reset();
        chk("err_cleared", ERR, 1'b0);

        load_word(10'h2A5);
        load_word(10'h013);
        load_word(10'h3FF);
        chk("load3_count", COUNT, 5'd3);
        chk("load3_state", STATE, 2'b00);
        run_key();
        chk("run_state", STATE, 2'b01);
        chk("run_w0", DATA_OUT, 10'h2A5);
        chk("run_valid", DATA_VALID, 1'b1);
        chk("run_rdptr", RD_PTR, 4'd0);
        load_word(10'h155);
        chk("load_in_run_ignored", COUNT, 5'd3);
        ext_pulse();
        chk("run_w1", DATA_OUT, 10'h013);
        chk("run_rdptr1", RD_PTR, 4'd1);
        ext_pulse();
        chk("run_w2", DATA_OUT, 10'h3FF);
        ext_pulse();
        chk("halt_state", STATE, 2'b10);
        chk("halt_valid", DATA_VALID, 1'b0);
        chk("halt_data", DATA_OUT, 10'd0);
        chk("halt_rdptr", RD_PTR, 4'd0);
        chk("halt_count", COUNT, 5'd3);
        chk("halt_err", ERR, 1'b0);

        ext_pulse();
        chk("ext_halt_err", ERR, 1'b1);
        chk("ext_halt_state", STATE, 2'b10);
        load_word(10'h0AA);
        chk("load_in_halt_ignored", COUNT, 5'd3);
        chk("load_in_halt_state", STATE, 2'b10);
        run_key();
        chk("replay_state", STATE, 2'b01);
        chk("replay_w0", DATA_OUT, 10'h2A5);
        ext_pulse();
        chk("replay_w1", DATA_OUT, 10'h013);
        ext_pulse();
        chk("replay_w2", DATA_OUT, 10'h3FF);
        ext_pulse();
        chk("replay_halt", STATE, 2'b10);

        do_reset();
        load_word(10'h111);
        load_word(10'h222);
        SW_DATA = 10'h333;
        LOAD_STB = 1'b1;
        RUN_STB = 1'b1;
        tick();
        LOAD_STB = 1'b0;
        RUN_STB = 1'b0;
        tick();
        chk("simul_count", COUNT, 5'd3);
        chk("simul_state", STATE, 2'b00);
        run_key();
        chk("simul_run_w0", DATA_OUT, 10'h111);
        ext_pulse();
        ext_pulse();
        chk("mid_rdptr", RD_PTR, 4'd2);
        chk("mid_w2", DATA_OUT, 10'h333);
        RST = 1'b1;
        EXT = 1'b1;
        #1;
        chk("in_rst_valid", DATA_VALID, 1'b0);
        chk("in_rst_data", DATA_OUT, 10'd0);
        tick();
        EXT = 1'b0;
        chk("midrst_state", STATE, 2'b00);
        chk("midrst_count", COUNT, 5'd0);
        chk("midrst_rdptr", RD_PTR, 4'd0);
        chk("midrst_valid", DATA_VALID, 1'b0);
        chk("midrst_err", ERR, 1'b0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) load_word(wv(i));
        chk("full_count", COUNT, 5'd16);
        chk("full_err", ERR, 1'b0);
        load_word(10'h3C3);
        chk("ovf_count", COUNT, 5'd16);
        chk("ovf_err", ERR, 1'b1);
        run_key();
        chk("ovf_run_state", STATE, 2'b01);
        for (int i = 0; i < 16; i++) begin
            chk("full_rdptr", RD_PTR, 32'(i));
            chk("full_word", DATA_OUT, wv(i));
            ext_pulse();
        end
        chk("full_halt", STATE, 2'b10);
        chk("full_halt_rdptr", RD_PTR, 4'd0);
        chk("full_halt_count", COUNT, 5'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
